// File: rtl/simd_loop_pkg.sv
// Shared definitions for the SIMD loop-nest controller.
//   - loop_state_e : controller FSM states
//   - DEF_*        : default widths used by the top-level parameters
//   - max_groups() : number of per-group iteration tables that exist
package simd_loop_pkg;

  localparam int DEF_LOOP_ID_W     = 5;
  localparam int DEF_GROUP_ID_W    = 2;
  localparam int DEF_LOOP_ITER_W   = 16;
  localparam int DEF_GROUP_ENABLED = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } loop_state_e;

  // With grouping disabled every group id collapses onto a single table.
  function automatic int max_groups(input int group_id_w, input int group_enabled);
    return (group_enabled != 0) ? (1 << group_id_w) : 1;
  endfunction

endpackage

// File: rtl/simd_loop_counter.sv
// One level of the loop nest: an iteration counter with carry chaining.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear_i      synchronous clear (asserted on the way into a new run)
//   carry_in_i   the inner loops have wrapped this step (advance this counter)
//   limit_i      iterations-1 for this loop
//   carry_out_o  carry_in_i and this counter is at its limit (wraps this step)
module simd_loop_counter #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              carry_in_i,
  input  logic [ITER_W-1:0] limit_i,
  output logic              carry_out_o
);

  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              at_limit;

  assign at_limit    = (cnt_q == limit_i);
  assign carry_out_o = carry_in_i & at_limit;

  // cnt never passes limit_i, so the increment cannot overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (carry_in_i) begin
      cnt_d = at_limit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simd_loop_ctrl_group.sv
// Loop-nest iteration controller for the SIMD memory path. Generates the
// walker start pulse and the iter_done carry vector from per-group tables of
// iteration counts (loop 0 outermost, loop NUM_MAX_LOOPS-1 innermost).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               run request for loop_group_id (only taken in IDLE)
//   block_done          clears every per-group config write pointer
//   stall               freezes stepping while in RUN
//   cfg_loop_iter_v     config write strobe; no back-pressure: a write is
//                       either taken this cycle or silently dropped
//   cfg_loop_iter       iterations-1 for the next loop of cfg_loop_group_id
//   cfg_loop_group_id   group being configured
//   loop_group_id       group to run, sampled on an accepted start
//   loop_start          one-cycle walker start pulse
//   iter_done           carry vector, bit NUM_MAX_LOOPS = step, bit 0 = done
//   busy                high from accepted start until the cycle after done
//   done                one-cycle pulse on the final step
//   stall_cnt           RUN cycles spent stalled (only with SIMD_LOOP_STALL_CNT_EN)
// Build option: define SIMD_LOOP_STALL_CNT_EN to add the stall_cnt port/counter.
module simd_loop_ctrl_group
  import simd_loop_pkg::*;
#(
  parameter int LOOP_ID_W      = DEF_LOOP_ID_W,
  parameter int GROUP_ID_W     = DEF_GROUP_ID_W,
  parameter int LOOP_ITER_W    = DEF_LOOP_ITER_W,
  parameter int GROUP_ENABLED  = DEF_GROUP_ENABLED,
  parameter int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
  parameter int NUM_MAX_GROUPS = max_groups(GROUP_ID_W, GROUP_ENABLED)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   block_done,
  input  logic                   stall,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
  input  logic [GROUP_ID_W-1:0]  loop_group_id,
  output logic                   loop_start,
  output logic [NUM_MAX_LOOPS:0] iter_done,
  output logic                   busy,
  output logic                   done
`ifdef SIMD_LOOP_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  loop_state_e                 state_q, state_d;
  logic [GROUP_ID_W-1:0]       run_grp_q, run_grp_d;
  logic [LOOP_ID_W:0]          ptr_q   [NUM_MAX_GROUPS];
  logic [LOOP_ITER_W-1:0]      table_q [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
  logic [GROUP_ID_W-1:0]       cfg_grp, run_sel;
  logic                        cfg_we, cnt_clear, step;

  assign cfg_grp = (GROUP_ENABLED != 0) ? cfg_loop_group_id : '0;
  assign run_sel = (GROUP_ENABLED != 0) ? loop_group_id : '0;

  // Write pointer MSB set means the pointer sits at NUM_MAX_LOOPS (full).
  // The running group's table is frozen for the whole run.
  assign cfg_we = cfg_loop_iter_v && !block_done && !ptr_q[cfg_grp][LOOP_ID_W]
                  && !(busy && (cfg_grp == run_grp_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
        ptr_q[g] <= '0;
        for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
          table_q[g][l] <= '0;
        end
      end
    end else begin
      for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
        if (block_done) begin
          ptr_q[g] <= '0;
        end else if (cfg_we && (cfg_grp == GROUP_ID_W'(g))) begin
          table_q[g][ptr_q[g][LOOP_ID_W-1:0]] <= cfg_loop_iter;
          ptr_q[g] <= ptr_q[g] + 1'b1;
        end
      end
    end
  end

  // FSM: IDLE -> START (loop_start) -> PRIME (walker pipeline slot) -> RUN.
  always_comb begin
    state_d    = state_q;
    run_grp_d  = run_grp_q;
    loop_start = 1'b0;
    cnt_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = START;
          run_grp_d = run_sel;
          cnt_clear = 1'b1;
        end
      end
      START: begin
        loop_start = 1'b1;
        state_d    = PRIME;
      end
      PRIME: state_d = RUN;
      RUN: begin
        if (iter_done[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_grp_q <= '0;
    end else begin
      state_q   <= state_d;
      run_grp_q <= run_grp_d;
    end
  end

  assign step = (state_q == RUN) && !stall;
  assign busy = (state_q != IDLE);
  assign done = iter_done[0];
  assign iter_done[NUM_MAX_LOOPS] = step;

  // Carry ripples from the innermost loop outward; each level keeps its
  // own carry net so the chain is a plain acyclic path.
  for (genvar k = 0; k < NUM_MAX_LOOPS; k++) begin : g_loop
    logic c_in, c_out;
    if (k == NUM_MAX_LOOPS - 1) begin : g_inner
      assign c_in = step;
    end else begin : g_outer
      assign c_in = g_loop[k+1].c_out;
    end
    simd_loop_counter #(.ITER_W(LOOP_ITER_W)) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (cnt_clear),
      .carry_in_i  (c_in),
      .limit_i     (table_q[run_grp_q][k]),
      .carry_out_o (c_out)
    );
    assign iter_done[k] = c_out;
  end

`ifdef SIMD_LOOP_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (loop_start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
